// File: rtl/mux32_rr_arbiter.sv
// Round-robin owner arbiter for a shared 32:1 mux. Grant, select, valid and expired are registered, 1-cycle decision latency.
// Owner holds until done or request drop; ARB_TIMEOUT_EN adds MAX_HOLD preemption when others wait.
module mux32_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] req,
   input  logic        done,
   output logic [31:0] grant,
   output logic [4:0]  select,
   output logic        valid,
   output logic        expired
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [4:0]  last;
   logic [4:0]  winner;
   logic [4:0]  idx;
   logic        found;
   logic        any_req;
   logic        release_evt;
   logic        timeout;

   assign any_req = |req;

   // Scan from last+1 upward with wrap; the previous owner's own bit comes last.
   always_comb begin
      winner = last;
      idx    = last;
      found  = 1'b0;
      for (int k = 0; k < 32; k++) begin
         idx = last + 5'd1 + 5'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
   logic [7:0] hold_cnt;
   logic       others;

   assign others = |(req & ~grant);
   // A simultaneous done or request drop is an ordinary release, not a preemption.
   assign timeout = (state == BUSY) && (hold_cnt >= HOLD_LIM) && others && !done && req[select];
`else
   logic unused_cfg;
   assign unused_cfg = ^MAX_HOLD;
   assign timeout    = 1'b0;
`endif

   assign release_evt = done || !req[select] || timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= 32'd0;
         select  <= 5'd0;
         valid   <= 1'b0;
         expired <= 1'b0;
         last    <= 5'd31;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= 8'd0;
`endif
      end else begin
         expired <= 1'b0;
         case (state)
            IDLE: begin
               if (ena && any_req) begin
                  state  <= BUSY;
                  grant  <= 32'd1 << winner;
                  select <= winner;
                  last   <= winner;
                  valid  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt <= 8'd0;
`endif
               end
            end
            BUSY: begin
               if (release_evt) begin
                  expired <= timeout;
                  if (ena && any_req) begin
                     grant  <= 32'd1 << winner;
                     select <= winner;
                     last   <= winner;
`ifdef ARB_TIMEOUT_EN
                     hold_cnt <= 8'd0;
`endif
                  end else begin
                     // select is left alone so the mux output stays stable while idle.
                     state <= IDLE;
                     grant <= 32'd0;
                     valid <= 1'b0;
                  end
               end else begin
`ifdef ARB_TIMEOUT_EN
                  if (hold_cnt < HOLD_LIM)
                     hold_cnt <= hold_cnt + 8'd1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
